hdlc_deframer: RTL



---
 rtl/hdlc_pkg.sv | 15 +
 rtl/hdlc_bit_delay.sv | 47 ++++
 rtl/hdlc_deframer.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/hdlc_pkg.sv
// Shared types and constants for the HDLC deframer slice.
package hdlc_pkg;

    typedef enum logic [1:0] {
        HUNT = 2'd0,
        OPEN = 2'd1,
        DATA = 2'd2
    } state_e;

    localparam logic [7:0]  FLAG_BYTE  = 8'h7E;
    localparam int unsigned FLAG_DELAY = 7;
    localparam int unsigned FILL_W     = $clog2(FLAG_DELAY + 1);
    localparam int unsigned BIT_CNT_W  = 3;

endpackage

// File: rtl/hdlc_bit_delay.sv
// Seven-bit delay line that holds back data bits until they are known not to
// belong to a flag; the oldest bit leaves on each push once the line is full.
module hdlc_bit_delay
    import hdlc_pkg::*;
(
    input  logic clk,
    input  logic resetn,
    input  logic push,
    input  logic bit_in,
    input  logic clr,
    output logic exit_c,
    output logic exit_bit_c
);

    logic [FLAG_DELAY-1:0] sr_q, sr_d;
    logic [FILL_W-1:0]     fill_q, fill_d;
    logic                  full;

    assign full = (fill_q == FILL_W'(FLAG_DELAY));

    always_comb begin
        sr_d       = sr_q;
        fill_d     = fill_q;
        exit_c     = push & full & ~clr;
        exit_bit_c = sr_q[FLAG_DELAY-1];
        if (clr) begin
            sr_d   = '0;
            fill_d = '0;
        end else if (push) begin
            sr_d = {sr_q[FLAG_DELAY-2:0], bit_in};
            if (!full) begin
                fill_d = fill_q + FILL_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            sr_q   <= '0;
            fill_q <= '0;
        end else begin
            sr_q   <= sr_d;
            fill_q <= fill_d;
        end
    end

endmodule

// File: rtl/hdlc_deframer.sv
// Rebuilds HDLC frames from the bit decoder's stream: drops stuffing and flag
// bits, packs LSB-first bytes, and flags frame boundaries, aborts and errors.
// Optional frame statistics are enabled with HDLC_DEFRAMER_STATS_EN.
module hdlc_deframer
    import hdlc_pkg::*;
#(
    parameter int unsigned MIN_BYTES = 2,
    parameter int unsigned MAX_BYTES = 1024,
    parameter int unsigned CNT_W     = 11
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       bit_valid,
    input  logic       bit_in,
    input  logic       discard,
    input  logic       flag,
    input  logic       err,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       sof,
    output logic       eof,
    output logic       frame_abort,
    output logic       frame_err,
    output logic       in_frame
`ifdef HDLC_DEFRAMER_STATS_EN
    ,
    output logic [15:0] good_frames,
    output logic [15:0] bad_frames
`endif
);

    state_e               state_q, state_d;
    logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [7:0]           asm_q, asm_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [7:0]           byte_data_q, byte_data_d;
    logic                 byte_valid_q, byte_valid_d;
    logic                 sof_q, sof_d;
    logic                 eof_q, eof_d;
    logic                 abort_q, abort_d;
    logic                 ferr_q, ferr_d;
    logic                 in_frame_q, in_frame_d;

    logic data_bit_c, flag_c, err_c, push_c, clr_c;
    logic exit_c, exit_bit_c, cnt_ok_c;

    assign data_bit_c = bit_valid & ~discard & ~flag & ~err;
    assign flag_c     = bit_valid & flag;
    assign err_c      = bit_valid & err;
    assign push_c     = data_bit_c & (state_q != HUNT);
    assign clr_c      = flag_c | err_c | (state_q == HUNT);
    assign cnt_ok_c   = (cnt_q >= CNT_W'(MIN_BYTES)) && (cnt_q <= CNT_W'(MAX_BYTES));

    hdlc_bit_delay u_delay (
        .clk        (clk),
        .resetn     (resetn),
        .push       (push_c),
        .bit_in     (bit_in),
        .clr        (clr_c),
        .exit_c     (exit_c),
        .exit_bit_c (exit_bit_c)
    );

    // Frame FSM. DATA is entered on the first bit to leave the delay line, so
    // the leading bits of shared/back-to-back flags never open a frame.
    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        asm_d        = asm_q;
        cnt_d        = cnt_q;
        byte_data_d  = byte_data_q;
        byte_valid_d = 1'b0;
        sof_d        = 1'b0;
        eof_d        = 1'b0;
        abort_d      = 1'b0;
        ferr_d       = 1'b0;

        case (state_q)
            HUNT: begin
                if (flag_c) begin
                    state_d = OPEN;
                end
            end
            OPEN: begin
                if (err_c) begin
                    state_d = HUNT;
                end
            end
            DATA: begin
                if (flag_c) begin
                    if (bit_cnt_q == '0 && cnt_ok_c) begin
                        eof_d = 1'b1;
                    end else begin
                        ferr_d = 1'b1;
                    end
                    state_d   = OPEN;
                    bit_cnt_d = '0;
                    cnt_d     = '0;
                end else if (err_c) begin
                    abort_d   = 1'b1;
                    state_d   = HUNT;
                    bit_cnt_d = '0;
                    cnt_d     = '0;
                end
            end
            default: begin
                state_d = HUNT;
            end
        endcase

        if (exit_c) begin
            state_d          = DATA;
            asm_d[bit_cnt_q] = exit_bit_c;
            bit_cnt_d        = bit_cnt_q + BIT_CNT_W'(1);
            if (bit_cnt_q == BIT_CNT_W'(7)) begin
                if (cnt_q == CNT_W'(MAX_BYTES)) begin
                    ferr_d  = 1'b1;
                    state_d = HUNT;
                    cnt_d   = '0;
                end else begin
                    byte_valid_d = 1'b1;
                    byte_data_d  = asm_d;
                    sof_d        = (cnt_q == '0);
                    cnt_d        = cnt_q + CNT_W'(1);
                end
            end
        end

        in_frame_d = (state_d == DATA);
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q      <= HUNT;
            bit_cnt_q    <= '0;
            asm_q        <= '0;
            cnt_q        <= '0;
            byte_data_q  <= '0;
            byte_valid_q <= 1'b0;
            sof_q        <= 1'b0;
            eof_q        <= 1'b0;
            abort_q      <= 1'b0;
            ferr_q       <= 1'b0;
            in_frame_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            asm_q        <= asm_d;
            cnt_q        <= cnt_d;
            byte_data_q  <= byte_data_d;
            byte_valid_q <= byte_valid_d;
            sof_q        <= sof_d;
            eof_q        <= eof_d;
            abort_q      <= abort_d;
            ferr_q       <= ferr_d;
            in_frame_q   <= in_frame_d;
        end
    end

    assign byte_valid  = byte_valid_q;
    assign byte_data   = byte_data_q;
    assign sof         = sof_q;
    assign eof         = eof_q;
    assign frame_abort = abort_q;
    assign frame_err   = ferr_q;
    assign in_frame    = in_frame_q;

`ifdef HDLC_DEFRAMER_STATS_EN
    logic [15:0] good_q, good_d, bad_q, bad_d;

    // Saturating counters updated on the same edge that raises the pulse.
    always_comb begin
        good_d = good_q;
        bad_d  = bad_q;
        if (eof_d && good_q != 16'hFFFF) begin
            good_d = good_q + 16'd1;
        end
        if ((ferr_d || abort_d) && bad_q != 16'hFFFF) begin
            bad_d = bad_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            good_q <= '0;
            bad_q  <= '0;
        end else begin
            good_q <= good_d;
            bad_q  <= bad_d;
        end
    end

    assign good_frames = good_q;
    assign bad_frames  = bad_q;
`endif

endmodule
